// File: rtl/sec_key_pkg.sv
// Shared types and constants for the serial security-device key reader.
// The device window is BA13=0, BA12=1; key bits are read with nibble 0 on BA7..BA4.
package sec_key_pkg;

    localparam logic       WIN_BA13  = 1'b0;
    localparam logic       WIN_BA12  = 1'b1;
    localparam logic [3:0] RD_NIBBLE = 4'h0;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StCmdStb,
        StCmdGap,
        StRdStb,
        StRdGap,
        StFin
    } state_e;

endpackage

// File: rtl/sec_strobe_gen.sv
// Strobe timing for the device select line: registered sser_n, last-cycle sample pulse
// and gap-complete pulse. The cycle counter restarts whenever a strobe phase is entered.
module sec_strobe_gen #(
    parameter int unsigned STB_CYC = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic stb_next_i,
    input  logic stb_i,
    input  logic gap_i,
    output logic sser_n_o,
    output logic last_o,
    output logic gap_done_o
);
    localparam int unsigned CntW = $clog2(STB_CYC + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sser_n_q, sser_n_d;

    always_comb begin
        cnt_d    = stb_i ? cnt_q + CntW'(1) : '0;
        // Driven from the next state so the pin is a flop yet tracks the FSM exactly.
        sser_n_d = ~stb_next_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            sser_n_q <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            sser_n_q <= sser_n_d;
        end
    end

    assign sser_n_o   = sser_n_q;
    assign last_o     = stb_i && (cnt_q == CntW'(STB_CYC - 1));
    assign gap_done_o = gap_i;

endmodule

// File: rtl/sec_key_reader.sv
// Host-side sequencer: wins the shared bus, clocks the device unlock sequence with
// address-coded strobes, then shifts in the key one SDRD sample per read strobe.
module sec_key_reader
    import sec_key_pkg::*;
#(
    parameter int unsigned KEY_BITS = 32,
    parameter int unsigned CMD_LEN  = 4,
    parameter int unsigned STB_CYC  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*CMD_LEN-1:0]  cmd_seq,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [KEY_BITS-1:0]   key_out,
    output logic                  bus_req,
    input  logic                  bus_gnt,
    output logic [5:0]            ba,
    output logic                  br_w,
    output logic                  sser_n,
    input  logic                  sdrd
);
    localparam int unsigned IdxW = (CMD_LEN > 1) ? $clog2(CMD_LEN) : 1;
    localparam int unsigned BitW = $clog2(KEY_BITS + 1);

    state_e              state_q, state_d;
    logic [IdxW-1:0]     cmd_idx_q, cmd_idx_d;
    logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [KEY_BITS-1:0] key_q, key_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                bus_req_q, bus_req_d;
    logic [5:0]          ba_q, ba_d;
    logic                stb_last, gap_done;

    always_comb begin
        state_d   = state_q;
        cmd_idx_d = cmd_idx_q;
        bit_cnt_d = bit_cnt_q;
        key_d     = key_q;
        err_d     = err_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StReq;
                    key_d   = '0;
                    err_d   = 1'b0;
                end
            end
            StReq: begin
                if (bus_gnt) begin
                    state_d   = StCmdStb;
                    cmd_idx_d = '0;
                end
            end
            StCmdStb, StCmdGap, StRdStb, StRdGap: begin
                // Grant loss wins over everything, including a pending sample.
                if (!bus_gnt) begin
                    state_d = StFin;
                    err_d   = 1'b1;
                end else if (state_q == StCmdStb) begin
                    if (stb_last) state_d = StCmdGap;
                end else if (state_q == StCmdGap) begin
                    if (gap_done) begin
                        if (cmd_idx_q == IdxW'(CMD_LEN - 1)) begin
                            state_d   = StRdStb;
                            bit_cnt_d = '0;
                        end else begin
                            state_d   = StCmdStb;
                            cmd_idx_d = cmd_idx_q + IdxW'(1);
                        end
                    end
                end else if (state_q == StRdStb) begin
                    if (stb_last) begin
                        state_d   = StRdGap;
                        key_d     = {key_q[KEY_BITS-2:0], sdrd};
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                    end
                end else begin
                    if (gap_done) begin
                        state_d = (bit_cnt_q == BitW'(KEY_BITS)) ? StFin : StRdStb;
                    end
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_d    = (state_d != StIdle);
        done_d    = (state_d == StFin);
        bus_req_d = 1'b0;
        ba_d      = '0;
        unique case (state_d)
            StReq: bus_req_d = 1'b1;
            StCmdStb, StCmdGap: begin
                bus_req_d = 1'b1;
                ba_d      = {WIN_BA13, WIN_BA12, cmd_seq[{cmd_idx_d, 2'b00} +: 4]};
            end
            StRdStb, StRdGap: begin
                bus_req_d = 1'b1;
                ba_d      = {WIN_BA13, WIN_BA12, RD_NIBBLE};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cmd_idx_q <= '0;
            bit_cnt_q <= '0;
            key_q     <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bus_req_q <= 1'b0;
            ba_q      <= '0;
        end else begin
            state_q   <= state_d;
            cmd_idx_q <= cmd_idx_d;
            bit_cnt_q <= bit_cnt_d;
            key_q     <= key_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bus_req_q <= bus_req_d;
            ba_q      <= ba_d;
        end
    end

    sec_strobe_gen #(
        .STB_CYC (STB_CYC)
    ) u_strobe (
        .clk_i      (clk),
        .rst_i      (rst),
        .stb_next_i (state_d == StCmdStb || state_d == StRdStb),
        .stb_i      (state_q == StCmdStb || state_q == StRdStb),
        .gap_i      (state_q == StCmdGap || state_q == StRdGap),
        .sser_n_o   (sser_n),
        .last_o     (stb_last),
        .gap_done_o (gap_done)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign key_out = key_q;
    assign bus_req = bus_req_q;
    assign ba      = ba_q;
    assign br_w    = 1'b1;

endmodule

// File: tb/tb_sec_key_reader.sv
// Directed bench for sec_key_reader: behavioural device model plus vector table and
// hand-written sequences for grant loss, re-start, mid-run reset and short strobes.
module tb_sec_key_reader;
    localparam int unsigned KB  = 32;
    localparam int unsigned CL  = 4;
    localparam int unsigned SC  = 2;
    localparam int unsigned KB6 = 8;
    localparam int unsigned SC6 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // DUT A: default parameters
    logic          start_a = 1'b0;
    logic [15:0]   cmd_a   = '0;
    logic          gnt_a   = 1'b0;
    logic          sdrd_a  = 1'b0;
    logic          busy_a, done_a, err_a, req_a, brw_a, sser_a;
    logic [KB-1:0] key_a;
    logic [5:0]    ba_a;

    sec_key_reader #(.KEY_BITS(KB), .CMD_LEN(CL), .STB_CYC(SC)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .cmd_seq(cmd_a),
        .busy(busy_a), .done(done_a), .err(err_a), .key_out(key_a),
        .bus_req(req_a), .bus_gnt(gnt_a), .ba(ba_a), .br_w(brw_a),
        .sser_n(sser_a), .sdrd(sdrd_a)
    );

    // DUT B: short strobes, 8-bit key
    logic           start_b = 1'b0;
    logic [15:0]    cmd_b   = 16'h8A95;
    logic           gnt_b   = 1'b1;
    logic           sdrd_b  = 1'b0;
    logic           busy_b, done_b, err_b, req_b, brw_b, sser_b;
    logic [KB6-1:0] key_b;
    logic [5:0]     ba_b;

    sec_key_reader #(.KEY_BITS(KB6), .CMD_LEN(CL), .STB_CYC(SC6)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .cmd_seq(cmd_b),
        .busy(busy_b), .done(done_b), .err(err_b), .key_out(key_b),
        .bus_req(req_b), .bus_gnt(gnt_b), .ba(ba_b), .br_w(brw_b),
        .sser_n(sser_b), .sdrd(sdrd_b)
    );

    // Device model A: counts strobes, logs unlock addresses, serves key bits MSB first.
    logic [KB-1:0] model_key = '0;
    int            m_stb  = 0;
    int            m_low  = 0;
    int            m_wbad = 0;
    logic          m_prev = 1'b1;
    logic [5:0]    m_ba [CL];

    always @(negedge clk) begin
        if (!busy_a) begin
            m_stb  = 0;
            m_low  = 0;
            m_prev = 1'b1;
        end else begin
            if (!sser_a && m_prev) begin
                m_stb = m_stb + 1;
                m_low = 1;
                if (m_stb <= int'(CL)) m_ba[m_stb-1] = ba_a;
                else if (m_stb - int'(CL) <= int'(KB)) sdrd_a = model_key[int'(KB) - (m_stb - int'(CL))];
            end else if (!sser_a) begin
                m_low = m_low + 1;
            end else if (!m_prev && m_low != int'(SC)) begin
                m_wbad = m_wbad + 1;
            end
            m_prev = sser_a;
        end
    end

    // Device model B
    logic [KB6-1:0] b_key  = 8'hA5;
    int             b_stb  = 0;
    int             b_low  = 0;
    int             b_wbad = 0;
    logic           b_prev = 1'b1;

    always @(negedge clk) begin
        if (!busy_b) begin
            b_stb  = 0;
            b_low  = 0;
            b_prev = 1'b1;
        end else begin
            if (!sser_b && b_prev) begin
                b_stb = b_stb + 1;
                b_low = 1;
                if (b_stb > int'(CL) && b_stb - int'(CL) <= int'(KB6))
                    sdrd_b = b_key[int'(KB6) - (b_stb - int'(CL))];
            end else if (!sser_b) begin
                b_low = b_low + 1;
            end else if (!b_prev && b_low != int'(SC6)) begin
                b_wbad = b_wbad + 1;
            end
            b_prev = sser_b;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full run on DUT A; grant rises 'delay' cycles after the bus request appears.
    task automatic run_a(input logic [15:0] cmd, input logic [31:0] key, input int delay,
                         input int exp_cyc);
        int          n;
        int          wb0;
        logic        wait_ok;
        logic        seen;
        logic [23:0] exp_ba;
        logic [23:0] got_ba;
        model_key = key;
        cmd_a     = cmd;
        gnt_a     = (delay == 0);
        wb0       = m_wbad;
        wait_ok   = 1'b1;
        seen      = 1'b0;
        n         = 0;
        @(negedge clk);
        start_a = 1'b1;
        while (!seen && n < 2000) begin
            @(posedge clk);
            #1;
            start_a = 1'b0;
            n = n + 1;
            if (!gnt_a && (!sser_a || !req_a)) wait_ok = 1'b0;
            if (delay > 0 && n == delay + 1) gnt_a = 1'b1;
            seen = done_a;
        end
        chk("done_seen", 64'(seen), 64'(1));
        chk("run_cycles", 64'(n), 64'(exp_cyc));
        chk("err_ok", 64'(err_a), 64'(0));
        chk("key", 64'(key_a), 64'(key));
        chk("req_wait", 64'(wait_ok), 64'(1));
        exp_ba = {2'b01, cmd[3:0], 2'b01, cmd[7:4], 2'b01, cmd[11:8], 2'b01, cmd[15:12]};
        got_ba = {m_ba[0], m_ba[1], m_ba[2], m_ba[3]};
        chk("cmd_nibbles", 64'(got_ba), 64'(exp_ba));
        chk("strobe_width", 64'(m_wbad - wb0), 64'(0));
        @(posedge clk);
        #1;
        chk("idle_after", 64'({busy_a, done_a, req_a, sser_a, brw_a}), 64'(5'b00011));
    endtask

    typedef struct {
        logic [15:0] cmd;
        logic [31:0] key;
        int          delay;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int   n;
        int   strobes;
        int   dones;
        logic prev;
        logic seen;

        // Cycles = REQ wait + (CMD_LEN+KEY_BITS)*(STB_CYC+1) + FIN
        vecs[0] = '{16'h8A95, 32'hDEADBEEF, 0,  110};
        vecs[1] = '{16'h8A95, 32'hDEADBEEF, 10, 120};
        vecs[2] = '{16'h1234, 32'h00000001, 3,  113};
        vecs[3] = '{16'hF0F0, 32'hFFFFFFFF, 0,  110};
        vecs[4] = '{16'h0000, 32'h80000000, 1,  111};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", 64'({busy_a, done_a, err_a, req_a, sser_a, brw_a}), 64'(6'b000011));
        chk("reset_data", 64'({ba_a, key_a}), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_a(vecs[i].cmd, vecs[i].key, vecs[i].delay, vecs[i].exp_cyc);
        end

        // Grant dropped during read bit 7: only bits 0..6 make it into the key.
        model_key = 32'hDEADBEEF;
        cmd_a     = 16'h8A95;
        gnt_a     = 1'b1;
        strobes   = 0;
        prev      = 1'b1;
        n         = 0;
        @(negedge clk);
        start_a = 1'b1;
        while (strobes < int'(CL) + 8 && n < 2000) begin
            @(posedge clk);
            #1;
            start_a = 1'b0;
            n = n + 1;
            if (!sser_a && prev) strobes = strobes + 1;
            prev = sser_a;
        end
        chk("abort_reached", 64'(strobes), 64'(CL + 8));
        gnt_a = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_pins", 64'({sser_a, req_a, done_a, err_a}), 64'(4'b1011));
        chk("abort_key", 64'(key_a), 64'(32'h6F));
        gnt_a = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_idle", 64'({busy_a, done_a}), 64'(2'b00));

        // Second start while busy is ignored.
        dones = 0;
        @(negedge clk);
        start_a = 1'b1;
        for (int i = 1; i <= 150; i++) begin
            @(posedge clk);
            #1;
            start_a = (i == 20);
            if (done_a) dones = dones + 1;
        end
        chk("one_done", 64'(dones), 64'(1));
        chk("restart_key", 64'(key_a), 64'(32'hDEADBEEF));
        chk("restart_err", 64'(err_a), 64'(0));

        // Reset in the middle of the unlock phase.
        @(negedge clk);
        start_a = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1;
            start_a = 1'b0;
        end
        chk("mid_cmd", 64'({busy_a, req_a, ba_a[5:4]}), 64'(4'b1101));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_ctl", 64'({busy_a, done_a, err_a, req_a, sser_a, brw_a}), 64'(6'b000011));
        chk("rst_data", 64'({ba_a, key_a}), 64'(0));
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (done_a) dones = dones + 1;
        end
        chk("rst_no_done", 64'(dones), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        run_a(16'h8A95, 32'hDEADBEEF, 0, 110);

        // STB_CYC=1, KEY_BITS=8: done at grant + 2*(4+8) + 1.
        n    = 0;
        seen = 1'b0;
        @(negedge clk);
        start_b = 1'b1;
        while (!seen && n < 500) begin
            @(posedge clk);
            #1;
            start_b = 1'b0;
            n = n + 1;
            seen = done_b;
        end
        chk("b_cycles", 64'(n), 64'(26));
        chk("b_key", 64'(key_b), 64'(8'hA5));
        chk("b_err", 64'(err_b), 64'(0));
        chk("b_width", 64'(b_wbad), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
